bcd_stopwatch_ctrl: RTL

Run/pause/clear controller for a cascaded multi-digit BCD up-counter. A programmable prescaler turns the system clock into count ticks. On each tick the block steps the digit chain with decade carry, and it wraps from all-9s to zero. It sits between the push-button/control logic and the display path, and presents packed BCD digits plus one-cycle `tick` and `ovf` event strobes.

---
 rtl/bcd_stopwatch_ctrl_if.sv | 38 +++
 rtl/bcd_stopwatch_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Control/status bundle of the BCD stopwatch controller.
//
// Handshake semantics: there is no valid/ready pairing. start/stop/clear are
// level requests that the controller samples on every rising clock edge, and
// count/running/tick/ovf/state are registered outputs that are valid every
// cycle (tick and ovf are single-cycle event strobes).
//
// Signals:
//   start, stop, clear : control requests (master -> slave)
//   count              : packed BCD digits, digit 0 in count[3:0]
//   running            : high while the FSM is in RUN
//   tick               : one-cycle pulse when count has just stepped
//   ovf                : one-cycle pulse together with tick on wrap to zero
//   state              : FSM state, exposed for debug/observation
interface bcd_stopwatch_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic [4*DIGITS-1:0]   count;
  logic                  running;
  logic                  tick;
  logic                  ovf;
  logic [1:0]            state;

  // Control logic side: drives the requests, observes the status.
  modport master (
    output start, stop, clear,
    input  count, running, tick, ovf, state
  );

  // Stopwatch controller side.
  modport slave (
    input  start, stop, clear,
    output count, running, tick, ovf, state
  );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear controller for a cascaded BCD up-counter.
//
// A prescaler divides clk by DIV while in RUN; each time it wraps the digit
// chain steps by one with decade carry, wrapping from all-9s to all-0s.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous active-low reset
//   bus    : bcd_stopwatch_ctrl_if.slave (start/stop/clear in;
//            count/running/tick/ovf/state out, all registered)
//
// Parameters:
//   DIGITS : number of BCD digits (>= 1)
//   DIV    : clk cycles per count tick while running (>= 1)
module bcd_stopwatch_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 10
) (
  input  logic                clk,
  input  logic                reset,
  bcd_stopwatch_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  localparam int            PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);

  logic [1:0]          state;
  logic [PW-1:0]       pre;
  logic [4*DIGITS-1:0] count;
  logic                running;
  logic                tick;
  logic                ovf;

  // Incremented digit chain and wrap flag, used only on a tick edge.
  logic [4*DIGITS-1:0] count_inc;
  logic                wrap;

  // Ripple the carry from digit 0 upwards: a digit steps only while every
  // lower digit was 9. A carry out of the top digit means all digits were 9.
  always_comb begin
    logic carry;
    logic [3:0] d;
    count_inc = count;
    carry     = 1'b1;
    d         = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count[4*i +: 4];
      if (carry) begin
        if (d >= 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = d + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      pre     <= '0;
      count   <= '0;
      running <= 1'b0;
      tick    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      // Event strobes are high only on the edge that performs a tick.
      tick <= 1'b0;
      ovf  <= 1'b0;
      if (bus.clear) begin
        state   <= S_IDLE;
        pre     <= '0;
        count   <= '0;
        running <= 1'b0;
      end else if (bus.stop) begin
        // Prescaler and count hold; IDLE ignores stop, PAUSE stays PAUSE.
        if (state != S_IDLE) begin
          state <= S_PAUSE;
        end
        running <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              state   <= S_RUN;
              pre     <= '0;
              running <= 1'b1;
            end
          end
          S_PAUSE: begin
            // Resume keeps the held prescaler value; the resume edge itself
            // is not a RUN edge, so the prescaler does not advance here.
            if (bus.start) begin
              state   <= S_RUN;
              running <= 1'b1;
            end
          end
          S_RUN: begin
            if (pre == PRE_MAX) begin
              pre   <= '0;
              count <= count_inc;
              tick  <= 1'b1;
              ovf   <= wrap;
            end else begin
              pre <= pre + PRE_ONE;
            end
          end
          default: begin
            state   <= S_IDLE;
            pre     <= '0;
            count   <= '0;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.count   = count;
  assign bus.running = running;
  assign bus.tick    = tick;
  assign bus.ovf     = ovf;
  assign bus.state   = state;

endmodule
